// File: rtl/usr_serial_rx_if.sv
// usr_serial_rx_if
// Bundles the serial input side, the parallel output handshake and the status
// signals of usr_serial_rx. clk/rst are kept outside as plain ports.
//   master : the environment (serial source + word sink) drives the inputs
//   slave  : the receiver drives data_out/data_valid/busy/bit_cnt/overflow/state_dbg
//
// Handshake: data_out is presented while data_valid=1 and is consumed on the
// rising edge where data_valid & data_ready are both 1. While data_valid=1 and
// data_ready=0, data_out is held stable. data_valid never depends
// combinationally on data_ready.
interface usr_serial_rx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             ser_in;
  logic             ser_valid;
  logic             dir;
  logic             sync;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overflow;
  logic             clr_ovf;
  logic             state_dbg;

  modport master (
    output ser_in, ser_valid, dir, sync, data_ready, clr_ovf,
    input  data_out, data_valid, busy, bit_cnt, overflow, state_dbg
  );

  modport slave (
    input  ser_in, ser_valid, dir, sync, data_ready, clr_ovf,
    output data_out, data_valid, busy, bit_cnt, overflow, state_dbg
  );
endinterface

// File: rtl/usr_serial_rx.sv
// usr_serial_rx
// Serial-to-parallel receiver for the universal shift register's serial output.
// Rebuilds WIDTH-bit words shifted out either LSB-first (dir=0) or MSB-first
// (dir=1) and hands them to a one-entry output buffer with valid/ready.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus (slave)    ser_in/ser_valid/dir/sync  serial input and realign
//                  data_out/data_valid/data_ready  output word handshake
//                  busy/bit_cnt                    partial-word status
//                  overflow/clr_ovf                sticky drop flag and its clear
//                  state_dbg                       FSM state (0=IDLE, 1=SHIFT)
module usr_serial_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  usr_serial_rx_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             first_bit;
  logic             last_bit;
  logic             eff_dir;
  logic             accept;
  logic             complete;
  logic             drain;
  logic [WIDTH-1:0] shifted;

  assign first_bit = (cnt_q == '0);
  assign last_bit  = (cnt_q == LAST_CNT);
  // The first bit of a word must follow the live dir: dir_q only captures it
  // on that same edge.
  assign eff_dir   = first_bit ? bus.dir : dir_q;
  // sync wins over a simultaneous bit, which is then discarded.
  assign accept    = bus.ser_valid & ~bus.sync;
  assign complete  = accept & last_bit;
  assign drain     = valid_q & bus.data_ready;
  // LSB-first enters at the top and walks down, so the first bit ends in [0];
  // MSB-first enters at the bottom and walks up, so the first bit ends in [WIDTH-1].
  assign shifted   = eff_dir ? {sreg_q[WIDTH-2:0], bus.ser_in}
                             : {bus.ser_in, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    // Word assembly
    if (bus.sync) begin
      sreg_d  = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (accept) begin
      if (first_bit) begin
        dir_d = bus.dir;
      end
      sreg_d = shifted;
      if (last_bit) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_SHIFT;
      end
    end

    // Clear first so that a drop in the same cycle re-sets the flag.
    if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end

    // Output buffer: a completed word loads if the slot is empty or being
    // drained on this edge; otherwise it is lost and flagged.
    if (complete) begin
      if (!valid_q || drain) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.overflow   = ovf_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
module tb_usr_serial_rx;
  localparam int W = 4;
  localparam int CW = $clog2(W);

  logic clk;
  logic rst;

  usr_serial_rx_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  usr_serial_rx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called when a handshake is about to complete on the next edge.
  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<no word queued>", tag, bus.data_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(bus.data_out), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    if (bus.data_valid && bus.data_ready) pop_check("word_out");
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    bus.ser_in    = b;
    bus.dir       = d;
    bus.ser_valid = 1'b1;
    tick();
    bus.ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic d);
    for (int i = 0; i < W; i++) begin
      send_bit(d ? w[W-1-i] : w[i], d);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] w;
    rst            = 1'b1;
    bus.ser_in     = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.dir        = 1'b0;
    bus.sync       = 1'b0;
    bus.data_ready = 1'b0;
    bus.clr_ovf    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // reset state
    check("rst_data_out",  32'(bus.data_out),   32'h0);
    check("rst_valid",     32'(bus.data_valid), 32'h0);
    check("rst_bit_cnt",   32'(bus.bit_cnt),    32'h0);
    check("rst_busy",      32'(bus.busy),       32'h0);
    check("rst_overflow",  32'(bus.overflow),   32'h0);
    check("rst_state",     32'(bus.state_dbg),  32'h0);

    // 1. LSB-first, consecutive bits 1,0,1,0 -> 0101, valid 1 clk after last edge
    exp_q.push_back(4'b0101);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t1_state_shift", 32'(bus.state_dbg), 32'h1);
    send_bit(1'b1, 1'b0);
    check("t1_valid_early", 32'(bus.data_valid), 32'h0);
    send_bit(1'b0, 1'b0);
    check("t1_valid",    32'(bus.data_valid), 32'h1);
    check("t1_data",     32'(bus.data_out),   32'h5);
    check("t1_state_idle", 32'(bus.state_dbg), 32'h0);
    bus.data_ready = 1'b1;
    tick();
    check("t1_drained",  32'(bus.data_valid), 32'h0);
    bus.data_ready = 1'b0;

    // 2. MSB-first with gaps, dir toggles after bit 1 (ignored)
    exp_q.push_back(4'b0101);
    send_bit(1'b0, 1'b1);
    check("t2_cnt1", 32'(bus.bit_cnt), 32'h1);
    tick();
    check("t2_cnt1_gap", 32'(bus.bit_cnt), 32'h1);
    send_bit(1'b1, 1'b0);
    check("t2_cnt2", 32'(bus.bit_cnt), 32'h2);
    tick();
    send_bit(1'b0, 1'b0);
    check("t2_cnt3", 32'(bus.bit_cnt), 32'h3);
    check("t2_busy", 32'(bus.busy),    32'h1);
    tick();
    send_bit(1'b1, 1'b0);
    check("t2_cnt0",  32'(bus.bit_cnt),    32'h0);
    check("t2_valid", 32'(bus.data_valid), 32'h1);
    check("t2_data",  32'(bus.data_out),   32'h5);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;

    // 3. Backpressure and overflow
    exp_q.push_back(4'b0011);
    send_word(4'b0011, 1'b0);
    check("t3_valid",   32'(bus.data_valid), 32'h1);
    check("t3_ovf0",    32'(bus.overflow),   32'h0);
    send_word(4'b1100, 1'b0);   // dropped
    check("t3_ovf1",    32'(bus.overflow),   32'h1);
    check("t3_data_held", 32'(bus.data_out), 32'h3);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow),   32'h0);
    // clear and drop on the same edge: set wins
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.clr_ovf = 1'b1;
    send_bit(1'b1, 1'b0);
    bus.clr_ovf = 1'b0;
    check("t3_set_wins", 32'(bus.overflow),  32'h1);
    check("t3_data_still", 32'(bus.data_out), 32'h3);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    bus.data_ready = 1'b1;
    tick();
    check("t3_valid_fall", 32'(bus.data_valid), 32'h0);
    check("t3_data_hold",  32'(bus.data_out),   32'h3);
    check("t3_ovf_final",  32'(bus.overflow),   32'h0);

    // 4. Back-to-back with data_ready=1
    exp_q.push_back(4'b1001);
    send_word(4'b1001, 1'b0);
    check("t4_valid_w1", 32'(bus.data_valid), 32'h1);
    check("t4_data_w1",  32'(bus.data_out),   32'h9);
    w = 4'b0110;
    exp_q.push_back(w);
    send_bit(w[0], 1'b0);
    check("t4_one_clk",  32'(bus.data_valid), 32'h0);
    for (int i = 1; i < W; i++) send_bit(w[i], 1'b0);
    check("t4_valid_w2", 32'(bus.data_valid), 32'h1);
    check("t4_data_w2",  32'(bus.data_out),   32'h6);
    check("t4_no_ovf",   32'(bus.overflow),   32'h0);
    tick();
    check("t4_drained",  32'(bus.data_valid), 32'h0);

    // 4b. Completion and drain on the same edge: valid stays 1, new word loads
    bus.data_ready = 1'b0;
    exp_q.push_back(4'b0111);
    send_word(4'b0111, 1'b0);
    w = 4'b1011;
    exp_q.push_back(w);
    for (int i = 0; i < W - 1; i++) send_bit(w[i], 1'b0);
    bus.data_ready = 1'b1;
    send_bit(w[W-1], 1'b0);
    check("t4b_valid", 32'(bus.data_valid), 32'h1);
    check("t4b_data",  32'(bus.data_out),   32'hb);
    check("t4b_ovf",   32'(bus.overflow),   32'h0);
    tick();
    check("t4b_drained", 32'(bus.data_valid), 32'h0);

    // 5. sync mid-word (with a simultaneous bit that must be discarded)
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t5_cnt_pre", 32'(bus.bit_cnt), 32'h2);
    bus.sync = 1'b1;
    send_bit(1'b1, 1'b0);
    bus.sync = 1'b0;
    check("t5_busy",  32'(bus.busy),      32'h0);
    check("t5_cnt",   32'(bus.bit_cnt),   32'h0);
    check("t5_state", 32'(bus.state_dbg), 32'h0);
    check("t5_valid_untouched", 32'(bus.data_valid), 32'h0);
    exp_q.push_back(4'b1000);
    send_word(4'b1000, 1'b0);
    check("t5_valid", 32'(bus.data_valid), 32'h1);
    check("t5_data",  32'(bus.data_out),   32'h8);
    tick();

    // 6. Reset mid-word with a buffered word
    bus.data_ready = 1'b0;
    exp_q.push_back(4'b1010);
    send_word(4'b1010, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_valid_pre", 32'(bus.data_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());   // buffered word is discarded by reset
    check("t6_rst_data",  32'(bus.data_out),   32'h0);
    check("t6_rst_valid", 32'(bus.data_valid), 32'h0);
    check("t6_rst_cnt",   32'(bus.bit_cnt),    32'h0);
    check("t6_rst_busy",  32'(bus.busy),       32'h0);
    check("t6_rst_ovf",   32'(bus.overflow),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    exp_q.push_back(4'b1110);
    send_word(4'b1110, 1'b1);
    check("t6_valid", 32'(bus.data_valid), 32'h1);
    check("t6_data",  32'(bus.data_out),   32'he);
    bus.data_ready = 1'b1;
    tick();
    check("t6_drained", 32'(bus.data_valid), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
